// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_bank slice.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rep_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, integrator, edge pulses and optional auto-repeat.
// Auto-repeat FSM is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   samp_c;
  logic                   flip_c;
  logic                   rise_c;
  logic                   fall_c;

  assign samp_c = sync_q[SYNC_STAGES-1];
  // The output flips on the STABLE_CYCLES-th consecutive differing sample.
  assign flip_c = (samp_c != clean) && (cnt_q == CNT_LAST);
  assign rise_c = flip_c & samp_c;
  assign fall_c = flip_c & ~samp_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      clean      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
      rise_pulse <= rise_c;
      fall_pulse <= fall_c;
      if (samp_c == clean || flip_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flip_c) begin
        clean <= samp_c;
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned HOLD_W = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  rep_state_t        rep_state;
  logic [HOLD_W-1:0] hold_cnt;

  // Release wins over any repeat due in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_state    <= IDLE;
      hold_cnt     <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      hold_cnt     <= hold_cnt + HOLD_W'(1);
      if (fall_c) begin
        rep_state <= IDLE;
        hold_cnt  <= '0;
      end else begin
        case (rep_state)
          IDLE: begin
            hold_cnt <= '0;
            if (rise_c) begin
              rep_state <= HOLD;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              rep_state    <= REPEAT;
              hold_cnt     <= '0;
              repeat_pulse <= 1'b1;
            end
          end
          REPEAT: begin
            if (hold_cnt == REPEAT_LAST) begin
              hold_cnt     <= '0;
              repeat_pulse <= 1'b1;
            end
          end
          default: begin
            rep_state <= IDLE;
            hold_cnt  <= '0;
          end
        endcase
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer for board buttons/switches; active-low pins are flipped by INVERT_MASK.
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat strobe.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH          = 5,
  parameter int unsigned     SYNC_STAGES   = 2,
  parameter int unsigned     STABLE_CYCLES = 1_000_000,
  parameter logic [N_CH-1:0] INVERT_MASK   = '0,
  parameter int unsigned     HOLD_CYCLES   = 50_000_000,
  parameter int unsigned     REPEAT_CYCLES = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  logic [N_CH-1:0] level_c;

  assign level_c = noisy_in ^ INVERT_MASK;

`ifndef DEBOUNCE_REPEAT_EN
  localparam int unsigned unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .din         (level_c[i]),
      .clean       (clean_out[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .repeat_pulse(repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (plain and channel-0 inverted) against a sliding-window model.
module tb_debounce_bank;

  localparam int NCH    = 3;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int REP    = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] noisy_in;
  logic [NCH-1:0] clean_out, rise_pulse, fall_pulse, repeat_pulse;
  logic [NCH-1:0] clean_i, rise_i, fall_i, repeat_i;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(NCH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .INVERT_MASK(3'b000), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in),
    .clean_out(clean_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .repeat_pulse(repeat_pulse)
  );

  debounce_bank #(
    .N_CH(NCH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .INVERT_MASK(3'b001), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_inv (
    .clk(clk), .reset(reset), .noisy_in(noisy_in),
    .clean_out(clean_i), .rise_pulse(rise_i),
    .fall_pulse(fall_i), .repeat_pulse(repeat_i)
  );

  logic [11:0] obs [2];
  assign obs[0] = {clean_out, rise_pulse, fall_pulse, repeat_pulse};
  assign obs[1] = {clean_i, rise_i, fall_i, repeat_i};

  int n_cmp  = 0;
  int n_fail = 0;
  int t      = 0;

  // Reference model: input delay line, window of the last STABLE samples, rise timestamp.
  logic [2:0]     masks [2] = '{3'b000, 3'b001};
  bit             pipe   [2][NCH][SYNC];
  bit             win    [2][NCH][STABLE];
  int             nv     [2][NCH];
  bit             mclean [2][NCH];
  int             rise_t [2][NCH];
  logic [NCH-1:0] e_clean [2], e_rise [2], e_fall [2], e_rep [2];

  function automatic logic [11:0] expv(input int m);
    return {e_clean[m], e_rise[m], e_fall[m], e_rep[m]};
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) begin
        bit x, s, r, f, rp, all_diff;
        int d;
        x  = noisy_in[c] ^ masks[m][c];
        r  = 1'b0;
        f  = 1'b0;
        rp = 1'b0;
        if (reset) begin
          for (int k = 0; k < SYNC; k++) pipe[m][c][k] = 1'b0;
          nv[m][c]     = 0;
          mclean[m][c] = 1'b0;
          rise_t[m][c] = -1;
        end else begin
          s = pipe[m][c][SYNC-1];
          for (int k = SYNC - 1; k > 0; k--) pipe[m][c][k] = pipe[m][c][k-1];
          pipe[m][c][0] = x;
          for (int k = STABLE - 1; k > 0; k--) win[m][c][k] = win[m][c][k-1];
          win[m][c][0] = s;
          if (nv[m][c] < STABLE) nv[m][c]++;
          all_diff = (nv[m][c] >= STABLE);
          for (int k = 0; k < STABLE; k++) if (win[m][c][k] == mclean[m][c]) all_diff = 1'b0;
          if (all_diff) begin
            r = !mclean[m][c];
            f = mclean[m][c];
            mclean[m][c] = !mclean[m][c];
            rise_t[m][c] = r ? t : -1;
          end
          d = t - rise_t[m][c];
`ifdef DEBOUNCE_REPEAT_EN
          rp = mclean[m][c] && (rise_t[m][c] >= 0) &&
               ((d == HOLD) || ((d > HOLD) && ((d - HOLD) % REP == 0)));
`else
          rp = 1'b0;
`endif
        end
        e_clean[m][c] = mclean[m][c];
        e_rise[m][c]  = r;
        e_fall[m][c]  = f;
        e_rep[m][c]   = rp;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    noisy_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== 12'h000) begin
          n_fail++;
          $display("FAIL reset_zero dut%0d t=%0d got=%h want=000", m, t, obs[m]);
        end
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL reset_release dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      n_cmp++;
      if (clean_i[0] !== (k >= 6) || rise_i[0] !== (k == 6)) begin
        n_fail++;
        $display("FAIL inv_after_reset k=%0d got clean=%b rise=%b", k, clean_i[0], rise_i[0]);
      end
    end
  endtask

  task automatic test_step();
    noisy_in[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL step_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      n_cmp++;
      if (clean_out[0] !== (k >= 6) || rise_pulse[0] !== (k == 6)) begin
        n_fail++;
        $display("FAIL step_rise k=%0d got clean=%b rise=%b", k, clean_out[0], rise_pulse[0]);
      end
    end
    noisy_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL step_release dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      n_cmp++;
      if (fall_pulse[0] !== (k == 6) || clean_out[0] !== (k < 6)) begin
        n_fail++;
        $display("FAIL step_fall k=%0d got fall=%b clean=%b", k, fall_pulse[0], clean_out[0]);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 12; k++) begin
      noisy_in[1] = (k <= 3);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL glitch_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      n_cmp++;
      if ({clean_out[1], rise_pulse[1], fall_pulse[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch_quiet k=%0d got=%b want=000", k,
                 {clean_out[1], rise_pulse[1], fall_pulse[1]});
      end
    end
  endtask

  task automatic test_bounce();
    logic b [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int rises = 0;
    int rise_k = -1;
    for (int k = 1; k <= 27; k++) begin
      noisy_in[2] = (k <= 9) ? b[k-1] : (k <= 19);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL bounce_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      if (rise_pulse[2] === 1'b1) begin
        rises++;
        rise_k = k;
      end
    end
    n_cmp++;
    if (rises !== 1 || rise_k !== 11) begin
      n_fail++;
      $display("FAIL bounce_single got rises=%0d at k=%0d want 1 at k=11", rises, rise_k);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 1; k <= 18; k++) begin
      noisy_in = (k <= 10) ? 3'b111 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL simul_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (rise_pulse !== 3'b111 || rise_i !== 3'b110 || fall_i !== 3'b001) begin
          n_fail++;
          $display("FAIL simul_press got rise=%b inv_rise=%b inv_fall=%b want 111 110 001",
                   rise_pulse, rise_i, fall_i);
        end
      end
      if (k == 16) begin
        n_cmp++;
        if (fall_pulse !== 3'b111 || fall_i !== 3'b110 || rise_i !== 3'b001) begin
          n_fail++;
          $display("FAIL simul_release got fall=%b inv_fall=%b inv_rise=%b want 111 110 001",
                   fall_pulse, fall_i, rise_i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    noisy_in = 3'b010;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== 12'h000) begin
          n_fail++;
          $display("FAIL midreset_zero dut%0d t=%0d got=%h want=000", m, t, obs[m]);
        end
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL midreset_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      n_cmp++;
      if (clean_out[1] !== (k >= 6) || rise_pulse[1] !== (k == 6)) begin
        n_fail++;
        $display("FAIL midreset_latency k=%0d got clean=%b rise=%b", k, clean_out[1], rise_pulse[1]);
      end
    end
    noisy_in = 3'b000;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_repeat();
    logic [31:0] hits = '0;
    logic [31:0] want;
    noisy_in[0] = 1'b1;
    for (int k = 1; k <= 6 + 24 + 12; k++) begin
      if (k == 31) noisy_in[0] = 1'b0;
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL repeat_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
      if (k > 6 && k <= 30 && repeat_pulse[0] === 1'b1) hits[k-6] = 1'b1;
      if (k > 37) begin
        n_cmp++;
        if (repeat_pulse[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL repeat_after_fall k=%0d got=%b want=0", k, repeat_pulse[0]);
        end
      end
    end
`ifdef DEBOUNCE_REPEAT_EN
    want = (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 22);
`else
    want = 32'd0;
`endif
    n_cmp++;
    if (hits !== want) begin
      n_fail++;
      $display("FAIL repeat_times got=%h want=%h", hits, want);
    end
  endtask

  task automatic test_random();
    int rst_left = 0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) noisy_in[c] = ~noisy_in[c];
      end
      if (rst_left == 0 && $urandom_range(0, 119) == 0) rst_left = $urandom_range(1, 3);
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs[m] !== expv(m)) begin
          n_fail++;
          $display("FAIL random_model dut%0d t=%0d got=%h want=%h", m, t, obs[m], expv(m));
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
